// File: rtl/ram_arbiter_pkg.sv
// Shared constants and encodings for the two-port RAM arbiter.
// RAM_CLEAR_EN (define to enable) compiles in the RAM clear engine.
package ram_arbiter_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } owner_e;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-requester round-robin decision: on a tie the requester that was
// not granted most recently wins.
module rr_arb2
   import ram_arbiter_pkg::*;
(
   input  logic   req_a,
   input  logic   req_b,
   input  owner_e last,
   output logic   gnt_a,
   output logic   gnt_b
);

   assign gnt_a = req_a & (~req_b | (last == GNT_B));
   assign gnt_b = req_b & (~req_a | (last == GNT_A));

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one ram32x4 between requesters A and B.
// Define RAM_CLEAR_EN to add the clear engine (CLEAR state, busy, clear_done).
module ram_arbiter #(
   parameter int ADDR_W = ram_arbiter_pkg::ADDR_W,
   parameter int DATA_W = ram_arbiter_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] rdata,
   input  logic              clear_start,
   output logic              busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);
   import ram_arbiter_pkg::*;

   owner_e last_q, last_d;
   logic   a_rv_q, a_rv_d;
   logic   b_rv_q, b_rv_d;
   logic   arb_en, arb_a, arb_b;

   rr_arb2 u_rr (
      .req_a (a_req),
      .req_b (b_req),
      .last  (last_q),
      .gnt_a (arb_a),
      .gnt_b (arb_b)
   );

`ifdef RAM_CLEAR_EN
   state_e            st_q, st_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
`else
   logic unused_clear_start;
   assign unused_clear_start = clear_start;
   assign busy       = 1'b0;
   assign clear_done = 1'b0;
`endif

   // Reset gates the RAM port combinationally so a reset cycle never writes.
   always_comb begin
      arb_en   = ~reset;
      a_gnt    = 1'b0;
      b_gnt    = 1'b0;
      ram_wren = 1'b0;
      ram_addr = a_addr;
      ram_data = a_wdata;
`ifdef RAM_CLEAR_EN
      st_d       = st_q;
      cnt_d      = cnt_q;
      busy       = (st_q == ST_CLEAR);
      clear_done = 1'b0;
      if (!reset) begin
         if (st_q == ST_CLEAR) begin
            arb_en   = 1'b0;
            ram_addr = cnt_q;
            ram_data = '0;
            ram_wren = 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) begin
               clear_done = 1'b1;
               st_d       = ST_IDLE;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end else if (clear_start) begin
            arb_en = 1'b0;
            st_d   = ST_CLEAR;
            cnt_d  = '0;
         end
      end
`endif
      if (arb_en) begin
         a_gnt = arb_a;
         b_gnt = arb_b;
         if (arb_b) begin
            ram_addr = b_addr;
            ram_data = b_wdata;
         end
         ram_wren = (arb_a & a_we) | (arb_b & b_we);
      end
   end

   assign last_d = a_gnt ? GNT_A : (b_gnt ? GNT_B : last_q);
   assign a_rv_d = a_gnt & ~a_we;
   assign b_rv_d = b_gnt & ~b_we;

   assign a_rvalid = a_rv_q;
   assign b_rvalid = b_rv_q;
   assign rdata    = (a_rv_q | b_rv_q) ? ram_q : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= GNT_B;
         a_rv_q <= 1'b0;
         b_rv_q <= 1'b0;
`ifdef RAM_CLEAR_EN
         st_q   <= ST_IDLE;
         cnt_q  <= '0;
`endif
      end else begin
         last_q <= last_d;
         a_rv_q <= a_rv_d;
         b_rv_q <= b_rv_d;
`ifdef RAM_CLEAR_EN
         st_q   <= st_d;
         cnt_q  <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a synchronous ram32x4 stand-in
// and a timestamp-based round-robin reference model.
module tb_ram_arbiter;

   logic       clk;
   logic       reset;
   logic       a_req, a_we, b_req, b_we;
   logic [4:0] a_addr, b_addr;
   logic [3:0] a_wdata, b_wdata;
   logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [3:0] rdata;
   logic       clear_start, busy, clear_done;
   logic [4:0] ram_addr;
   logic [3:0] ram_data;
   logic       ram_wren;
   logic [3:0] ram_q;

   ram_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .a_req       (a_req),
      .a_we        (a_we),
      .a_addr      (a_addr),
      .a_wdata     (a_wdata),
      .a_gnt       (a_gnt),
      .a_rvalid    (a_rvalid),
      .b_req       (b_req),
      .b_we        (b_we),
      .b_addr      (b_addr),
      .b_wdata     (b_wdata),
      .b_gnt       (b_gnt),
      .b_rvalid    (b_rvalid),
      .rdata       (rdata),
      .clear_start (clear_start),
      .busy        (busy),
      .clear_done  (clear_done),
      .ram_addr    (ram_addr),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read RAM stand-in; ram_init zeroes it at start of run.
   logic       ram_init;
   logic [3:0] ram_mem [32];
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 32; i++) ram_mem[i] <= 4'h0;
      end else if (ram_wren) begin
         ram_mem[ram_addr] <= ram_data;
      end
      ram_q <= ram_mem[ram_addr];
   end

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         a_last_t, b_last_t;
   logic       exp_a_rv, exp_b_rv;
   logic [3:0] exp_rd;
   logic [3:0] mem_m [32];
   bit         a_hold, b_hold;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      a_last_t = -2;
      b_last_t = -1;
      exp_a_rv = 1'b0;
      exp_b_rv = 1'b0;
   endtask

   // One arbitrated cycle: predict from the model, check at negedge, update.
   task automatic arb_cycle();
      logic ga, gb;
      ga = a_req && (!b_req || (a_last_t < b_last_t));
      gb = b_req && !ga;
      @(negedge clk);
      check("a_gnt", 32'(a_gnt), 32'(ga));
      check("b_gnt", 32'(b_gnt), 32'(gb));
      check("ram_wren", 32'(ram_wren), 32'((ga && a_we) || (gb && b_we)));
      if (ga) check("ram_addr_a", 32'(ram_addr), 32'(a_addr));
      if (gb) check("ram_addr_b", 32'(ram_addr), 32'(b_addr));
      if (ga && a_we) check("ram_data_a", 32'(ram_data), 32'(a_wdata));
      if (gb && b_we) check("ram_data_b", 32'(ram_data), 32'(b_wdata));
      check("a_rvalid", 32'(a_rvalid), 32'(exp_a_rv));
      check("b_rvalid", 32'(b_rvalid), 32'(exp_b_rv));
      if (exp_a_rv || exp_b_rv) check("rdata", 32'(rdata), 32'(exp_rd));
      check("busy_idle", 32'(busy), 32'd0);
      check("clear_done_idle", 32'(clear_done), 32'd0);
      exp_a_rv = ga && !a_we;
      exp_b_rv = gb && !b_we;
      if (ga) begin
         a_last_t = cyc;
         if (a_we) mem_m[a_addr] = a_wdata;
         else exp_rd = mem_m[a_addr];
      end
      if (gb) begin
         b_last_t = cyc;
         if (b_we) mem_m[b_addr] = b_wdata;
         else exp_rd = mem_m[b_addr];
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_req = 1'b0;
      b_req = 1'b0;
      @(negedge clk);
      check("rst_a_gnt", 32'(a_gnt), 32'd0);
      check("rst_wren", 32'(ram_wren), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

`ifdef RAM_CLEAR_EN
   // Drives clear_start then follows the 32 clear writes; abort_at >= 0
   // asserts reset in that clear cycle instead of finishing.
   task automatic clear_run(input int abort_at);
      bit aborted;
      aborted = 1'b0;
      clear_start = 1'b1;
      @(negedge clk);
      check("cs_a_gnt", 32'(a_gnt), 32'd0);
      check("cs_b_gnt", 32'(b_gnt), 32'd0);
      check("cs_wren", 32'(ram_wren), 32'd0);
      check("cs_a_rvalid", 32'(a_rvalid), 32'(exp_a_rv));
      check("cs_b_rvalid", 32'(b_rvalid), 32'(exp_b_rv));
      if (exp_a_rv || exp_b_rv) check("cs_rdata", 32'(rdata), 32'(exp_rd));
      exp_a_rv = 1'b0;
      exp_b_rv = 1'b0;
      cyc++;
      @(posedge clk);
      #1;
      for (int k = 0; k < 32 && !aborted; k++) begin
         if (k == abort_at) begin
            reset = 1'b1;
            clear_start = 1'b0;
            @(negedge clk);
            check("abort_wren", 32'(ram_wren), 32'd0);
            check("abort_done", 32'(clear_done), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("post_abort_wren", 32'(ram_wren), 32'd0);
            check("post_abort_busy", 32'(busy), 32'd0);
            check("post_abort_done", 32'(clear_done), 32'd0);
            @(posedge clk);
            #1;
            reset = 1'b0;
            model_reset();
            aborted = 1'b1;
         end else begin
            clear_start = (k == 12);
            @(negedge clk);
            check("clr_busy", 32'(busy), 32'd1);
            check("clr_wren", 32'(ram_wren), 32'd1);
            check("clr_addr", 32'(ram_addr), 32'(k));
            check("clr_data", 32'(ram_data), 32'd0);
            check("clr_a_gnt", 32'(a_gnt), 32'd0);
            check("clr_b_gnt", 32'(b_gnt), 32'd0);
            check("clr_a_rvalid", 32'(a_rvalid), 32'd0);
            check("clr_done", 32'(clear_done), 32'(k == 31));
            mem_m[k] = 4'h0;
            cyc++;
            @(posedge clk);
            #1;
         end
      end
      clear_start = 1'b0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 32; i++) mem_m[i] = 4'h0;
      model_reset();
      a_hold = 1'b0;
      b_hold = 1'b0;
      exp_rd = 4'h0;
      reset = 1'b1;
      ram_init = 1'b1;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      clear_start = 1'b0;
      @(posedge clk);
      #1;
      // Reset must dominate requests and clear_start in the same cycle.
      a_req = 1'b1;
      b_req = 1'b1;
      clear_start = 1'b1;
      @(negedge clk);
      check("reset_a_gnt", 32'(a_gnt), 32'd0);
      check("reset_b_gnt", 32'(b_gnt), 32'd0);
      check("reset_wren", 32'(ram_wren), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_clear_done", 32'(clear_done), 32'd0);
      check("reset_a_rvalid", 32'(a_rvalid), 32'd0);
      check("reset_b_rvalid", 32'(b_rvalid), 32'd0);
      check("reset_rdata", 32'(rdata), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      ram_init = 1'b0;
      clear_start = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
      model_reset();

      // Write then read on A.
      a_req = 1'b1; a_we = 1'b1; a_addr = 5'd5; a_wdata = 4'd9;
      arb_cycle();
      a_we = 1'b0;
      arb_cycle();
      a_req = 1'b0;
      @(negedge clk);
      check("wr_rd_rvalid", 32'(a_rvalid), 32'd1);
      check("wr_rd_rdata", 32'(rdata), 32'd9);
      exp_a_rv = 1'b0;
      cyc++;
      @(posedge clk);
      #1;

      // Simultaneous requests after reset alternate A, B, A, B.
      do_reset();
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5;
      b_req = 1'b1; b_we = 1'b0; b_addr = 5'd2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("tie_order_a", 32'(a_gnt), 32'(i % 2 == 0));
         check("tie_order_b", 32'(b_gnt), 32'(i % 2 == 1));
         @(posedge clk);
         #1;
      end
      a_req = 1'b0;
      b_req = 1'b0;

      // Lone requester B is granted back to back.
      do_reset();
      b_req = 1'b1; b_we = 1'b1; b_addr = 5'd7; b_wdata = 4'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("lone_b_gnt", 32'(b_gnt), 32'd1);
         @(posedge clk);
         #1;
      end
      mem_m[7] = 4'd3;
      b_req = 1'b0;

      // Randomized traffic against the reference model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if (!a_hold) begin
            a_req   = 1'($urandom_range(0, 1));
            a_we    = 1'($urandom_range(0, 1));
            a_addr  = 5'($urandom_range(0, 31));
            a_wdata = 4'($urandom_range(0, 15));
            a_hold  = a_req;
         end
         if (!b_hold) begin
            b_req   = 1'($urandom_range(0, 1));
            b_we    = 1'($urandom_range(0, 1));
            b_addr  = 5'($urandom_range(0, 31));
            b_wdata = 4'($urandom_range(0, 15));
            b_hold  = b_req;
         end
         arb_cycle();
         if (a_last_t == cyc - 1) a_hold = 1'b0;
         if (b_last_t == cyc - 1) b_hold = 1'b0;
      end
      a_req = 1'b0;
      b_req = 1'b0;
      arb_cycle();

`ifdef RAM_CLEAR_EN
      // Clear: preload 31=F, read it on B just before clear_start, hold A during clear.
      a_req = 1'b1; a_we = 1'b1; a_addr = 5'd31; a_wdata = 4'hF;
      arb_cycle();
      a_req = 1'b0;
      b_req = 1'b1; b_we = 1'b0; b_addr = 5'd31;
      arb_cycle();
      b_req = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd31;
      clear_run(-1);
      arb_cycle();
      a_req = 1'b0;
      arb_cycle();

      // Reset in clear cycle 10 leaves addresses 10..31 intact.
      a_req = 1'b1; a_we = 1'b1;
      for (int i = 8; i < 32; i++) begin
         a_addr  = 5'(i);
         a_wdata = 4'((i % 15) + 1);
         arb_cycle();
      end
      a_req = 1'b0;
      arb_cycle();
      clear_run(10);
      a_req = 1'b1; a_we = 1'b0;
      a_addr = 5'd9;  arb_cycle();
      a_addr = 5'd10; arb_cycle();
      a_addr = 5'd20; arb_cycle();
      a_addr = 5'd31; arb_cycle();
      a_req = 1'b0;
      arb_cycle();
      arb_cycle();
`else
      // Without the clear engine clear_start is ignored.
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5;
      clear_start = 1'b1;
      arb_cycle();
      clear_start = 1'b0;
      a_req = 1'b0;
      arb_cycle();
      arb_cycle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
- REQ-001 Parameters SHALL be:
  - ADDR_W, 5, RAM address width (32 words).
  - DATA_W, 4, RAM data width.
- REQ-002 Ports SHALL be, one per line, in this order:
  - clk  in  1  single clock; all state updates on its rising edge.
  - reset  in  1  synchronous, active-high reset.
  - a_req  in  1  requester A access request.
  - a_we  in  1  requester A write enable (1 = write, 0 = read).
  - a_addr  in  ADDR_W  requester A address.
  - a_wdata  in  DATA_W  requester A write data.
  - a_gnt  out  1  requester A access issued this cycle.
  - a_rvalid  out  1  requester A read data valid.
  - b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid  same as A, for requester B.
  - rdata  out  DATA_W  read data, shared by both requesters and qualified by a_rvalid or b_rvalid.
  - clear_start  in  1  one-cycle pulse that starts a RAM clear.
  - busy  out  1  clear in progress.
  - clear_done  out  1  one-cycle pulse on the final clear write.
  - ram_addr  out  ADDR_W  to ram32x4 address.
  - ram_data  out  DATA_W  to ram32x4 data.
  - ram_wren  out  1  to ram32x4 write enable.
  - ram_q  in  DATA_W  from ram32x4 q.

Function
- REQ-003 The block SHALL issue at most one RAM access per clk cycle, combinationally driving ram_addr, ram_data and ram_wren from the granted requester.
- REQ-004 Handshake: a requester SHALL hold req, we, addr and wdata stable until it sees gnt=1; gnt SHALL be high for exactly the cycle in which its access drives the RAM.
- REQ-005 Read latency: x_rvalid SHALL be 1 exactly one cycle after a granted read, with rdata = ram_q; writes SHALL NOT raise rvalid.
- REQ-006 Back-to-back accesses SHALL be allowed: a requester holding req high is granted every cycle in which the other requester is not requesting.
- REQ-007 Arbitration SHALL be round-robin:
  - When both request in the same cycle, grant goes to the requester not granted most recently.
  - last_grant updates only on an actual grant.
- REQ-008 When no grant is issued, ram_wren SHALL be 0; ram_addr and ram_data are don't-care.
- REQ-009 States SHALL be IDLE (arbitrating) and CLEAR.
- REQ-010 IDLE -> CLEAR on clear_start=1, taking priority over any pending req in the same cycle; no gnt in that cycle.
- REQ-011 CLEAR operation:
  - Writes DATA_W'b0 to addresses 0..31 in ascending order, one per cycle (32 cycles).
  - busy=1 and both gnt=0 throughout.
  - clear_start is ignored while in CLEAR.
- REQ-012 CLEAR -> IDLE after the write to address 31; clear_done=1 in that write cycle; requests are serviced from the next cycle.
- REQ-013 The clear address counter SHALL be ADDR_W bits and SHALL NOT wrap; termination is on count = 2^ADDR_W-1.
- REQ-014 An rvalid due from a read granted in the cycle before clear_start SHALL still be delivered.

Reset
- REQ-015 On reset=1 at a clk edge, the block SHALL return to the following values:
  - state = IDLE.
  - last_grant = B, so A wins the first tie.
  - Clear counter = 0.
  - busy, clear_done, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wren = 0.
  - rdata = 0.
- REQ-016 Reset during CLEAR SHALL abort the clear immediately: no further clear writes, no clear_done.
- REQ-017 Reset SHALL take priority over clear_start and all requests in the same cycle.

Configuration
- REQ-018 Macro RAM_CLEAR_EN defined SHALL compile in the CLEAR state, clear counter, busy and clear_done logic.
- REQ-019 Without RAM_CLEAR_EN:
  - clear_start SHALL be ignored.
  - busy and clear_done SHALL be tied 0.
  - The block SHALL be a pure round-robin arbiter; port list unchanged.

Structure
- REQ-020 A shared package/header SHALL hold:
  - Constants ADDR_W=5 and DATA_W=4.
  - State encodings ST_IDLE and ST_CLEAR.
  - Grant-owner encodings GNT_A and GNT_B.
- REQ-021 The two-requester round-robin decision SHALL be a sub-module rr_arb2 (inputs req_a, req_b, last; outputs gnt_a, gnt_b); ram32x4 itself stays outside this block.

Verification
- REQ-022 Write then read on A:
  - Stimulus: a_we=1, a_addr=5, a_wdata=9, then a_we=0, a_addr=5.
  - Required: a_gnt on each of the two cycles; a_rvalid=1 with rdata=9 one cycle after the read grant.
- REQ-023 Simultaneous requests after reset:
  - Stimulus: a_req and b_req held high for 4 cycles.
  - Required: grants in order A, B, A, B.
- REQ-024 Lone requester:
  - Stimulus: b_req held for 3 cycles, a_req=0.
  - Required: b_gnt=1 on all 3 cycles.
- REQ-025 Clear with RAM_CLEAR_EN:
  - Stimulus: preload addr 31 = F; pulse clear_start.
  - Required: busy for 32 cycles; clear_done on the 32nd; a subsequent read of addr 31 returns 0.
- REQ-026 Clear blocks requests:
  - Stimulus: a_req held during CLEAR.
  - Required: a_gnt=0 until the cycle after clear_done, then a_gnt=1.
- REQ-027 Reset mid-clear:
  - Stimulus: reset asserted at clear cycle 10.
  - Required: ram_wren=0 from the next cycle; clear_done never pulses; addresses 10..31 keep their prior contents.
